// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches, buffers responses
// with their PCs in a small queue, and handles ID stalls and redirects.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW:0]    LP_DEPTH = (CW+1)'(DEPTH);
  localparam logic [31:0]    NOP      = 32'h0000_0013;

  logic [31:0]   r_pc_q  [DEPTH];
  logic [31:0]   r_ins_q [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, r_outstanding, r_drop_cnt;
  logic [31:0]   r_fetch_pc, r_rsp_pc;

  logic          w_fire, w_rsp, w_drop, w_enq, w_deq;
  logic [CW:0]   w_total;
  logic [CW-1:0] w_out_next;
  logic [31:0]   w_redirect_pc;

  // Queue slots plus in-flight requests never exceed DEPTH, so every response has room.
  assign w_total        = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (w_total < LP_DEPTH);
  assign imem_req_addr  = r_fetch_pc;

  assign w_fire        = imem_req_valid && imem_req_ready;
  assign w_rsp         = imem_rsp_valid && (r_outstanding != '0);
  assign w_drop        = w_rsp && (r_drop_cnt != '0);
  assign w_enq         = w_rsp && (r_drop_cnt == '0);
  assign w_deq         = if_valid && id_ready;
  assign w_out_next    = r_outstanding + CW'(w_fire) - CW'(w_rsp);
  assign w_redirect_pc = redirect_pc & ~32'h3;

  assign if_valid       = (r_count != '0);
  assign if_pc          = if_valid ? r_pc_q[r_head]  : 32'h0;
  assign if_instruction = if_valid ? r_ins_q[r_head] : NOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_enq) begin
          r_tail   <= r_tail + AW'(1);
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_deq) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && w_enq) begin
      r_pc_q[r_tail]  <= r_rsp_pc;
      r_ins_q[r_tail] <= imem_rsp_data;
    end
  end

endmodule
